// File: rtl/sccomp_pkg.sv
// Shared encodings for the single-cycle RV32I computer: opcodes, funct3 values,
// control enums and the immediate generator.
package sccomp_pkg;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LS_B  = 3'd0;
    localparam logic [2:0] F3_LS_H  = 3'd1;
    localparam logic [2:0] F3_LS_W  = 3'd2;
    localparam logic [2:0] F3_LS_BU = 3'd4;
    localparam logic [2:0] F3_LS_HU = 3'd5;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
        case (t)
            IMM_S:   gen_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   gen_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   gen_imm = {instr[31:12], 12'h000};
            IMM_J:   gen_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: gen_imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

    // alt selects SUB/SRA; the caller decides when instr[30] is meaningful.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_from_f3 = ALU_SLL;
            F3_SLT:  alu_from_f3 = ALU_SLT;
            F3_SLTU: alu_from_f3 = ALU_SLTU;
            F3_XOR:  alu_from_f3 = ALU_XOR;
            F3_SR:   alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/sccomp_if.sv
// Core-to-memory bus: instruction fetch port and data load/store port.
interface sccomp_if;
    logic [9:0]  iaddr;
    logic [31:0] instr;
    logic [11:0] daddr;
    logic [31:0] dwdata;
    logic        dwe;
    logic [2:0]  dfunct3;
    logic [31:0] drdata;

    modport master   (output iaddr, daddr, dwdata, dwe, dfunct3, input instr, drdata);
    modport im_slave (input iaddr, output instr);
    modport dm_slave (input daddr, dwdata, dwe, dfunct3, output drdata);
endinterface

// File: rtl/sccomp_dm.sv
// 4096 x 8 little-endian data RAM with combinational, bytewise-assembled loads.
module sccomp_dm
    import sccomp_pkg::*;
(
    input  logic       clk,
    sccomp_if.dm_slave bus
);
    logic [7:0]  dmem [0:4095];
    logic [11:0] a0, a1, a2, a3;
    logic [31:0] word;

    // 12-bit adds wrap, so accesses near the top spill into address 0.
    assign a0   = bus.daddr;
    assign a1   = bus.daddr + 12'd1;
    assign a2   = bus.daddr + 12'd2;
    assign a3   = bus.daddr + 12'd3;
    assign word = {dmem[a3], dmem[a2], dmem[a1], dmem[a0]};

    always_comb begin
        case (bus.dfunct3)
            F3_LS_B:  bus.drdata = {{24{word[7]}}, word[7:0]};
            F3_LS_H:  bus.drdata = {{16{word[15]}}, word[15:0]};
            F3_LS_W:  bus.drdata = word;
            F3_LS_BU: bus.drdata = {24'h0, word[7:0]};
            F3_LS_HU: bus.drdata = {16'h0, word[15:0]};
            default:  bus.drdata = '0;
        endcase
    end

    // NOTE: storage arrays get no reset branch; only state that must start known is reset.
    always_ff @(posedge clk) begin
        if (bus.dwe) begin
            dmem[a0] <= bus.dwdata[7:0];
            if (bus.dfunct3 != F3_LS_B) dmem[a1] <= bus.dwdata[15:8];
            if (bus.dfunct3 == F3_LS_W) begin
                dmem[a2] <= bus.dwdata[23:16];
                dmem[a3] <= bus.dwdata[31:24];
            end
        end
    end
endmodule

// File: rtl/sccomp_im.sv
// 1024 x 32 instruction ROM, contents preloaded by the environment.
module sccomp_im (
    sccomp_if.im_slave bus
);
    logic [31:0] ROM [0:1023];

    assign bus.instr = ROM[bus.iaddr];
endmodule

// File: rtl/sccomp_rf.sv
// 31 x 32 register file: two operand read ports, one debug read port, one write port.
module sccomp_rf (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  ra3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] rf [1:31];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < 32; i++) rf[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    // Reads see the pre-edge value; x0 has no storage and reads as zero.
    assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
    assign rd3 = (ra3 == 5'd0) ? '0 : rf[ra3];
endmodule

// File: rtl/sccpu.sv
// Single-cycle RV32I core: decode, immediate, ALU, branch/PC logic and register file.
module sccpu
    import sccomp_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data,
    output logic [31:0] PC_out,
    sccomp_if.master    bus
);
    logic [31:0] pc, instr, imm, rs1_val, rs2_val, alu_a, alu_b, alu_y;
    logic [31:0] wb_data, pc_plus4, next_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3;
    alu_op_e     alu_op;
    imm_type_e   imm_type;
    wb_sel_e     wb_sel;
    logic        reg_we, mem_we, a_is_pc, b_is_imm, is_branch, is_jal, is_jalr, taken;

    assign instr  = bus.instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        alu_op    = ALU_ADD;
        imm_type  = IMM_I;
        wb_sel    = WB_ALU;
        a_is_pc   = 1'b0;
        b_is_imm  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP_LUI:    begin reg_we = 1'b1; imm_type = IMM_U; b_is_imm = 1'b1; alu_op = ALU_PASS_B; end
            OP_AUIPC:  begin reg_we = 1'b1; imm_type = IMM_U; b_is_imm = 1'b1; a_is_pc = 1'b1; end
            OP_JAL:    begin reg_we = 1'b1; imm_type = IMM_J; wb_sel = WB_PC4; is_jal = 1'b1; end
            OP_JALR:   begin reg_we = 1'b1; b_is_imm = 1'b1; wb_sel = WB_PC4; is_jalr = 1'b1; end
            OP_BRANCH: begin imm_type = IMM_B; is_branch = 1'b1; end
            OP_LOAD: begin
                reg_we   = f3 inside {F3_LS_B, F3_LS_H, F3_LS_W, F3_LS_BU, F3_LS_HU};
                b_is_imm = 1'b1;
                wb_sel   = WB_MEM;
            end
            OP_STORE: begin
                mem_we   = f3 inside {F3_LS_B, F3_LS_H, F3_LS_W};
                imm_type = IMM_S;
                b_is_imm = 1'b1;
            end
            OP_IMM:    begin reg_we = 1'b1; b_is_imm = 1'b1; alu_op = alu_from_f3(f3, instr[30] && f3 == F3_SR); end
            OP_REG:    begin reg_we = 1'b1; alu_op = alu_from_f3(f3, instr[30]); end
            default:   ;
        endcase
    end

    assign imm   = gen_imm(instr, imm_type);
    assign alu_a = a_is_pc ? pc : rs1_val;
    assign alu_b = b_is_imm ? imm : rs2_val;
    assign shamt = alu_b[4:0];

    always_comb begin
        case (alu_op)
            ALU_ADD:    alu_y = alu_a + alu_b;
            ALU_SUB:    alu_y = alu_a - alu_b;
            ALU_SLL:    alu_y = alu_a << shamt;
            ALU_SLT:    alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_y = {31'h0, alu_a < alu_b};
            ALU_XOR:    alu_y = alu_a ^ alu_b;
            ALU_SRL:    alu_y = alu_a >> shamt;
            ALU_SRA:    alu_y = 32'($signed(alu_a) >>> shamt);
            ALU_OR:     alu_y = alu_a | alu_b;
            ALU_AND:    alu_y = alu_a & alu_b;
            default:    alu_y = alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            F3_BEQ:  taken = rs1_val == rs2_val;
            F3_BNE:  taken = rs1_val != rs2_val;
            F3_BLT:  taken = $signed(rs1_val) < $signed(rs2_val);
            F3_BGE:  taken = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: taken = rs1_val < rs2_val;
            F3_BGEU: taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        if (is_jalr)                          next_pc = {alu_y[31:1], 1'b0};
        else if (is_jal || (is_branch && taken)) next_pc = pc + imm;
        else                                  next_pc = pc_plus4;
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = bus.drdata;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_y;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc <= '0;
        else       pc <= next_pc;
    end

    sccomp_rf U_RF (
        .clk  (clk),
        .rstn (rstn),
        .ra1  (rs1),
        .ra2  (rs2),
        .ra3  (reg_sel),
        .rd1  (rs1_val),
        .rd2  (rs2_val),
        .rd3  (reg_data),
        .we   (reg_we),
        .wa   (rd),
        .wd   (wb_data)
    );

    // The store enable is masked by reset so nothing retires while reset is held.
    assign bus.iaddr   = pc[11:2];
    assign bus.daddr   = alu_y[11:0];
    assign bus.dwdata  = rs2_val;
    assign bus.dwe     = mem_we & rstn;
    assign bus.dfunct3 = f3;
    assign PC_out      = pc;
endmodule

// File: rtl/sccomp.sv
// Single-cycle RV32I computer: core, instruction ROM and data RAM with a register debug port.
module sccomp (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);
    sccomp_if bus ();

    logic [31:0] PC;
    logic [31:0] instr;

    sccpu U_SCPU (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .PC_out   (PC),
        .bus      (bus)
    );

    sccomp_im U_IM (.bus(bus));

    sccomp_dm U_DM (
        .clk (clk),
        .bus (bus)
    );

    assign instr = bus.instr;
endmodule

// File: tb/tb_sccomp.sv
// Scoreboard bench for sccomp: directed programs, expected values queued by stimulus
// and compared by an independent monitor on the falling clock edge.
module tb_sccomp;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  reg_sel = 5'd0;
    logic [31:0] reg_data;

    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] LD  = 7'h03;
    localparam logic [31:0] HALT_SELF = 32'h0000006F;

    typedef enum {K_PC, K_REG, K_MEM} kind_e;
    typedef struct {
        kind_e       kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    int    ld_idx = 0;

    sccomp dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic emit(input logic [31:0] w);
        dut.U_IM.ROM[ld_idx] = w;
        ld_idx++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input kind_e k, input int idx, input logic [31:0] v, input string nm);
        if (k == K_REG) reg_sel = 5'(idx);
        sb_q.push_back('{k, idx, v, nm});
    endtask

    task automatic check(input kind_e k, input int idx, input logic [31:0] v, input string nm);
        expect_val(k, idx, v, nm);
        cycle();
    endtask

    // Called at posedge+1: asserts reset mid-cycle and fills the ROM with self-loops.
    task automatic begin_prog();
        #1 rstn = 1'b0;
        for (int i = 0; i < 1024; i++) dut.U_IM.ROM[i] = HALT_SELF;
        ld_idx = 0;
    endtask

    // Returns just after the first executing edge.
    task automatic release_prog();
        check(K_PC, 0, 32'h0, "pc_held_in_reset");
        #2 rstn = 1'b1;
        cycle();
    endtask

    initial begin : monitor
        item_t       it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                case (it.kind)
                    K_PC:    act = dut.PC;
                    K_REG:   act = reg_data;
                    default: act = {24'h0, dut.U_DM.dmem[it.idx[11:0]]};
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_miss++;
                    $display("FAIL %s: got %08h, want %08h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] pc_seq [11];

        // Power-on reset held for 20 ns with the immediate-ALU program loaded.
        for (int i = 0; i < 1024; i++) dut.U_IM.ROM[i] = HALT_SELF;
        ld_idx = 0;
        emit(enc_i(5, 0, 0, 7, OPI));
        emit(enc_i(-8, 7, 0, 7, OPI));
        #1 expect_val(K_PC, 0, 32'h0, "pc_reset");
        #10 expect_val(K_REG, 7, 32'h0, "x7_reset");
        #9 rstn = 1'b1;
        cycle();
        check(K_REG, 7, 32'h5, "addi_first_edge");
        check(K_PC, 0, 32'h8, "pc_after_two");
        check(K_REG, 7, 32'hFFFFFFFD, "addi_negative");

        // Stores, sign/zero-extending loads, misaligned halfword, address wrap.
        begin_prog();
        emit(enc_u(32'h12345, 5, 7'h37));
        emit(enc_i(32'h678, 5, 0, 5, OPI));
        emit(enc_s(0, 5, 0, 2));
        emit(enc_i(3, 0, 0, 6, LD));
        emit(enc_i(0, 0, 5, 7, LD));
        emit(enc_i(128, 0, 0, 8, OPI));
        emit(enc_s(8, 8, 0, 0));
        emit(enc_i(8, 0, 0, 9, LD));
        emit(enc_i(8, 0, 4, 10, LD));
        emit(enc_s(5, 5, 0, 1));
        emit(enc_i(5, 0, 1, 11, LD));
        emit(enc_s(-1, 8, 0, 0));
        emit(enc_s(12, 5, 0, 2));
        emit(enc_s(13, 8, 0, 0));
        emit(enc_i(12, 0, 2, 12, LD));
        release_prog();
        repeat (16) cycle();
        check(K_REG, 5, 32'h12345678, "lui_addi");
        check(K_MEM, 0, 32'h78, "sw_byte0");
        check(K_MEM, 1, 32'h56, "sw_byte1");
        check(K_MEM, 2, 32'h34, "sw_byte2");
        check(K_MEM, 3, 32'h12, "sw_byte3");
        check(K_REG, 6, 32'h00000012, "lb_pos");
        check(K_REG, 7, 32'h00005678, "lhu");
        check(K_REG, 9, 32'hFFFFFF80, "lb_neg");
        check(K_REG, 10, 32'h00000080, "lbu");
        check(K_MEM, 5, 32'h78, "sh_mis_byte5");
        check(K_MEM, 6, 32'h56, "sh_mis_byte6");
        check(K_REG, 11, 32'h00005678, "lh_misaligned");
        check(K_MEM, 4095, 32'h80, "sb_wrap_4095");
        check(K_REG, 12, 32'h12348078, "sb_partial_lw");

        // Branches, jumps and the halt address, PC traced edge by edge.
        begin_prog();
        emit(enc_i(-1, 0, 0, 1, OPI));
        emit(enc_i(1, 0, 0, 2, OPI));
        emit(enc_b(8, 0, 0, 0));
        emit(enc_i(1, 0, 0, 3, OPI));
        emit(enc_b(8, 2, 1, 6));
        emit(enc_i(2, 0, 0, 4, OPI));
        emit(enc_j(16, 5));
        emit(enc_i(7, 0, 0, 6, OPI));
        ld_idx = 10;
        emit(enc_i(61, 0, 0, 7, OPI));
        emit(enc_i(0, 7, 0, 8, 7'h67));
        emit(enc_i(9, 0, 0, 9, OPI));
        ld_idx = 15;
        emit(enc_b(8, 2, 1, 4));
        emit(enc_i(10, 0, 0, 10, OPI));
        emit(enc_i(1, 0, 0, 0, OPI));
        emit(enc_i(-4, 0, 0, 0, 7'h67));
        pc_seq = '{32'd4, 32'd8, 32'd16, 32'd20, 32'd24, 32'd40, 32'd44,
                   32'd60, 32'd68, 32'd72, 32'hFFFFFFFC};
        release_prog();
        for (int i = 0; i < 11; i++) check(K_PC, 0, pc_seq[i], $sformatf("pc_trace_%0d", i + 1));
        check(K_PC, 0, 32'hFFFFFFFC, "pc_halt_stays");
        check(K_REG, 1, 32'hFFFFFFFF, "x1_minus1");
        check(K_REG, 3, 32'h0, "beq_skipped");
        check(K_REG, 4, 32'h2, "bltu_not_taken");
        check(K_REG, 5, 32'd28, "jal_link");
        check(K_REG, 6, 32'h0, "jal_skipped");
        check(K_REG, 8, 32'd48, "jalr_link");
        check(K_REG, 9, 32'h0, "jalr_skipped");
        check(K_REG, 10, 32'h0, "blt_skipped");
        check(K_REG, 0, 32'h0, "x0_write_dropped");

        // Register/immediate ALU ops, remaining branches, unsupported opcode as NOP.
        begin_prog();
        emit(enc_i(-16, 0, 0, 1, OPI));
        emit(enc_i(32'h402, 1, 5, 2, OPI));
        emit(enc_i(28, 1, 5, 3, OPI));
        emit(enc_i(1, 1, 2, 4, OPI));
        emit(enc_i(1, 1, 3, 5, OPI));
        emit(enc_i(35, 0, 0, 6, OPI));
        emit(enc_r(0, 6, 6, 1, 7));
        emit(enc_r(32'h20, 6, 0, 0, 8));
        emit(enc_i(-1, 6, 4, 9, OPI));
        emit(enc_r(0, 1, 6, 6, 10));
        emit(enc_r(0, 1, 6, 7, 11));
        emit(enc_r(32'h20, 6, 1, 5, 12));
        emit(enc_r(0, 6, 1, 2, 13));
        emit(enc_r(0, 6, 1, 3, 14));
        emit(enc_u(1, 15, 7'h17));
        emit(enc_b(8, 0, 1, 5));
        emit(enc_b(8, 0, 1, 7));
        emit(enc_i(1, 0, 0, 16, OPI));
        emit(enc_b(8, 0, 0, 1));
        emit(enc_i(17, 0, 0, 17, OPI));
        emit(enc_i(1, 0, 1, 19, 7'h73));
        emit(enc_i(18, 0, 0, 18, OPI));
        release_prog();
        repeat (24) cycle();
        check(K_REG, 2, 32'hFFFFFFFC, "srai");
        check(K_REG, 3, 32'h0000000F, "srli");
        check(K_REG, 4, 32'h1, "slti");
        check(K_REG, 5, 32'h0, "sltiu");
        check(K_REG, 7, 32'h00000118, "sll_shamt5");
        check(K_REG, 8, 32'hFFFFFFDD, "sub");
        check(K_REG, 9, 32'hFFFFFFDC, "xori");
        check(K_REG, 10, 32'hFFFFFFF3, "or");
        check(K_REG, 11, 32'h00000020, "and");
        check(K_REG, 12, 32'hFFFFFFFE, "sra");
        check(K_REG, 13, 32'h1, "slt");
        check(K_REG, 14, 32'h0, "sltu");
        check(K_REG, 15, 32'h00001038, "auipc");
        check(K_REG, 16, 32'h0, "bgeu_taken_skip");
        check(K_REG, 17, 32'd17, "bne_not_taken");
        check(K_REG, 19, 32'h0, "system_nop");
        check(K_REG, 18, 32'd18, "after_nop");
        check(K_PC, 0, 32'd88, "pc_program_end");

        // Mid-run reset: PC clears between edges, registers clear and stay cleared.
        #1 rstn = 1'b0;
        check(K_PC, 0, 32'h0, "pc_async_reset");
        for (int i = 0; i < 32; i++) check(K_REG, i, 32'h0, $sformatf("x%0d_cleared", i));
        check(K_PC, 0, 32'h0, "pc_held_reset");
        #2 rstn = 1'b1;
        cycle();
        check(K_PC, 0, 32'h4, "pc_restart");
        check(K_REG, 1, 32'hFFFFFFF0, "x1_restart");

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
